// File: rtl/p2s_mc.sv
// Multi-channel parallel-to-serial stage: round-robin block intake, MSB-first beat slicing, output FIFO.
// Optional build macro P2S_PARITY_EN appends an even-parity LSB to every FIFO entry and d_out.
module p2s_mc #(
  parameter  int BLOCK_LENGTH = 128,
  parameter  int IO_WIDTH     = 8,
  parameter  int NUM_CH       = 2,
  parameter  int FIFO_DEPTH   = 16,
  localparam int BEATS        = BLOCK_LENGTH / IO_WIDTH,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef P2S_PARITY_EN
  localparam int PAR_W        = 1,
`else
  localparam int PAR_W        = 0,
`endif
  localparam int OUT_W        = 2 + CH_W + IO_WIDTH + PAR_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  in_valid,
  output logic [NUM_CH-1:0]                  in_ready,
  input  logic [NUM_CH*(BLOCK_LENGTH+1)-1:0] in_data,
  input  logic                               hold_o,
  output logic                               fifo_almost_full,
  output logic                               fifo_full,
  output logic                               done,
  output logic [OUT_W-1:0]                   d_out
);
  localparam int EW    = OUT_W - 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]         ptr_q, ptr_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    eop_q, eop_d;
  logic [BLOCK_LENGTH-1:0] shreg_q, shreg_d;
  logic [OUT_W-1:0]        d_out_q, d_out_d;
  logic                    done_q, done_d;
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]             count_q, count_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];

  logic [NUM_CH-1:0][BLOCK_LENGTH-1:0] blk;
  logic [NUM_CH-1:0]                   eop_in;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign blk[c]    = in_data[c*(BLOCK_LENGTH+1)+1 +: BLOCK_LENGTH];
    assign eop_in[c] = in_data[c*(BLOCK_LENGTH+1)];
  end

  // Round-robin: lowest valid index at/after ptr wins, else wrap to lowest valid overall.
  logic            any_vld, hi_vld;
  logic [CH_W-1:0] hi_idx, lo_idx, gnt_idx;
  always_comb begin
    any_vld = |in_valid;
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = CH_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_idx = CH_W'(i);
          hi_vld = 1'b1;
        end
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
  end

  logic          full_w, last_w, wr, arb_en, take, pop, beat_eop;
  logic [IO_WIDTH-1:0] beat;
  logic [EW-1:0]       entry;

  assign full_w   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign last_w   = (cnt_q == CNT_W'(BEATS - 1));
  assign wr       = (state_q == SHIFT) && !full_w;
  // Arbiter is open in IDLE and on the cycle the last beat actually gets written.
  assign arb_en   = !rst && ((state_q == IDLE) || (wr && last_w));
  assign take     = arb_en && any_vld;
  assign in_ready = take ? (NUM_CH'(1) << gnt_idx) : '0;
  assign pop      = !hold_o && (count_q != '0);
  assign beat     = shreg_q[BLOCK_LENGTH-1 -: IO_WIDTH];
  assign beat_eop = last_w ? eop_q : 1'b0;

`ifdef P2S_PARITY_EN
  assign entry = {beat_eop, ch_q, beat, ^{beat_eop, ch_q, beat}};
`else
  assign entry = {beat_eop, ch_q, beat};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    eop_d   = eop_q;
    shreg_d = shreg_q;
    if (wr) begin
      shreg_d = shreg_q << IO_WIDTH;
      cnt_d   = last_w ? '0 : cnt_q + 1'b1;
      if (last_w) state_d = IDLE;
    end
    if (take) begin
      shreg_d = blk[gnt_idx];
      ch_d    = gnt_idx;
      eop_d   = eop_in[gnt_idx];
      ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_comb begin
    wptr_d  = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    d_out_d = pop ? {1'b1, mem_q[rptr_q]} : {1'b0, d_out_q[EW-1:0]};
    done_d  = d_out_q[OUT_W-1] && d_out_q[OUT_W-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ch_q    <= '0;
      eop_q   <= 1'b0;
      shreg_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      d_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      eop_q   <= eop_d;
      shreg_q <= shreg_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      d_out_q <= d_out_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wptr_q] <= entry;
  end

  assign fifo_full        = full_w;
  assign fifo_almost_full = (count_q >= (AW+1)'(FIFO_DEPTH - 2));
  assign done             = done_q;
  assign d_out            = d_out_q;
endmodule

// File: tb/tb_p2s_mc.sv
// Directed bench for p2s_mc: 8-bit/2-channel instance plus a 128-bit/1-channel instance.
module tb_p2s_mc;
  localparam int BL = 128, IOW = 8, NCH = 2, DEP = 16, CHW = 1;
`ifdef P2S_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int OUT_W = 2 + CHW + IOW + PW, EW = OUT_W - 1;
  localparam int OUT_W5 = 3 + BL + PW, EW5 = OUT_W5 - 1;

  logic clk = 1'b0, rst = 1'b1, hold_o = 1'b0;
  logic [NCH-1:0] in_valid = '0, in_ready;
  logic [NCH*(BL+1)-1:0] in_data = '0;
  logic fifo_almost_full, fifo_full, done;
  logic [OUT_W-1:0] d_out;

  logic v5 = 1'b0, r5, hold5 = 1'b0, af5, full5, done5;
  logic [BL:0] d5 = '0;
  logic [OUT_W5-1:0] dout5;

  p2s_mc #(.BLOCK_LENGTH(BL), .IO_WIDTH(IOW), .NUM_CH(NCH), .FIFO_DEPTH(DEP)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold_o(hold_o), .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .done(done), .d_out(d_out));

  p2s_mc #(.BLOCK_LENGTH(BL), .IO_WIDTH(BL), .NUM_CH(1), .FIFO_DEPTH(DEP)) u_w128 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in_data(d5),
    .hold_o(hold5), .fifo_almost_full(af5), .fifo_full(full5),
    .done(done5), .d_out(dout5));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorders; tests index them from a base taken at the start of each step.
  logic [EW-1:0]  beats[$];
  int             bcyc[$], dcyc[$], af_rise[$], full_rise[$];
  logic [EW5-1:0] beats5[$];
  int             bcyc5[$], dcyc5[$];
  logic af_prev = 1'b0, full_prev = 1'b0;
  always @(negedge clk) begin
    if (d_out[OUT_W-1]) begin beats.push_back(d_out[EW-1:0]); bcyc.push_back(cyc); end
    if (done) dcyc.push_back(cyc);
    if (fifo_almost_full && !af_prev) af_rise.push_back(cyc);
    if (fifo_full && !full_prev) full_rise.push_back(cyc);
    af_prev = fifo_almost_full;
    full_prev = fifo_full;
    if (dout5[OUT_W5-1]) begin beats5.push_back(dout5[EW5-1:0]); bcyc5.push_back(cyc); end
    if (done5) dcyc5.push_back(cyc);
  end

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] bval(input int c, input int b, input int k);
    return 8'((c * 4 + b) * 16 + k);
  endfunction

  function automatic logic [BL-1:0] blk(input int c, input int b);
    logic [BL-1:0] r;
    for (int k = 0; k < 16; k++) r[BL-1-8*k -: 8] = bval(c, b, k);
    return r;
  endfunction

  function automatic logic [EW-1:0] mk(input logic e, input logic c, input logic [7:0] d);
`ifdef P2S_PARITY_EN
    return {e, c, d, ^{e, c, d}};
`else
    return {e, c, d};
`endif
  endfunction

  function automatic logic [EW5-1:0] mk5(input logic [BL-1:0] d);
`ifdef P2S_PARITY_EN
    return {1'b1, 1'b0, d, ^{1'b1, 1'b0, d}};
`else
    return {1'b1, 1'b0, d};
`endif
  endfunction

  function automatic logic [BL-1:0] b5(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Producer model: channel c offers nblk[c] blocks, next one presented right after each grant.
  int nblk[2], sent[2], grants[$], acc[$];
  task automatic feed_init(input int n0, input int n1);
    nblk[0] = n0; nblk[1] = n1; sent[0] = 0; sent[1] = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid[c] = (nblk[c] > 0);
      in_data[c*(BL+1) +: BL+1] = {blk(c, 0), 1'b1};
    end
  endtask

  task automatic feed_run(input int maxc, input bit strict);
    logic [NCH-1:0] g;
    bit bad = 0;
    for (int i = 0; i < maxc && in_valid != '0; i++) begin
      @(negedge clk);
      g = in_ready;
      if ((g & (g - 1'b1)) != '0) bad = 1;
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) if (g[c]) begin
        grants.push_back(c);
        acc.push_back(cyc);
        sent[c]++;
        if (sent[c] < nblk[c]) in_data[c*(BL+1) +: BL+1] = {blk(c, sent[c]), 1'b1};
        else in_valid[c] = 1'b0;
      end
    end
    chk("ready_onehot", bad, 0);
    if (strict) chk("feed_timeout_valid_left", in_valid, 0);
  endtask

  task automatic wait_beats(input int base, input int n, input int maxc);
    for (int i = 0; i < maxc && beats.size() < base + n; i++) tick(1);
    tick(3);
  endtask

  int exp_c[$], exp_b[$];
  task automatic check_stream(input string tag, input int base);
    int nb;
    nb = exp_c.size() * 16;
    chk({tag, "_beat_count"}, beats.size() - base, nb);
    for (int j = 0; j < exp_c.size(); j++)
      for (int k = 0; k < 16; k++)
        if (base + j*16 + k < beats.size())
          chk($sformatf("%s_beat%0d", tag, j*16 + k), beats[base + j*16 + k],
              mk(k == 15, 1'(exp_c[j]), bval(exp_c[j], exp_b[j], k)));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  int bs, ds, gs, as0, fs;
  initial begin
    // Reset state, with valids asserted to show in_ready stays low.
    in_valid = 2'b11; v5 = 1'b1;
    tick(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_w128", r5, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_done", done, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_almost_full", fifo_almost_full, 0);
    in_valid = '0; v5 = 1'b0;
    rst = 1'b0;
    tick(2);

    // T1: single ch0 block 0x00..0x0F with eop.
    bs = beats.size(); ds = dcyc.size(); as0 = acc.size();
    feed_init(1, 0);
    #1 chk("t1_ready_comb", in_ready, 2'b01);
    feed_run(10, 1);
    wait_beats(bs, 16, 40);
    exp_c = {0}; exp_b = {0};
    check_stream("t1", bs);
    if (beats.size() >= bs + 16) begin
      chk("t1_latency", bcyc[bs], acc[as0] + 2);
      chk("t1_gapless", bcyc[bs+15] - bcyc[bs], 15);
      chk("t1_done_count", dcyc.size() - ds, 1);
      if (dcyc.size() > ds) chk("t1_done_cycle", dcyc[ds], bcyc[bs+15] + 1);
    end

    // T2: both channels, two blocks each, alternating gapless grants.
    do_reset();
    bs = beats.size(); ds = dcyc.size(); gs = grants.size();
    feed_init(2, 2);
    feed_run(200, 1);
    wait_beats(bs, 64, 100);
    chk("t2_grant0", grants[gs+0], 0);
    chk("t2_grant1", grants[gs+1], 1);
    chk("t2_grant2", grants[gs+2], 0);
    chk("t2_grant3", grants[gs+3], 1);
    exp_c = {0, 1, 0, 1}; exp_b = {0, 0, 1, 1};
    check_stream("t2", bs);
    if (beats.size() >= bs + 64) chk("t2_gapless", bcyc[bs+63] - bcyc[bs], 63);
    chk("t2_done_count", dcyc.size() - ds, 4);

    // T3: hold_o stalls the FIFO while three blocks are offered.
    do_reset();
    hold_o = 1'b1;
    bs = beats.size(); as0 = acc.size(); fs = af_rise.size(); gs = grants.size();
    feed_init(2, 1);
    feed_run(40, 0);
    chk("t3_no_output_in_hold", beats.size() - bs, 0);
    chk("t3_full", fifo_full, 1);
    chk("t3_almost_full", fifo_almost_full, 1);
    chk("t3_ready_stalled", in_ready, 0);
    chk("t3_af_at_14", af_rise.size() > fs ? af_rise[fs] - acc[as0] : -1, 14);
    chk("t3_full_at_16", full_rise.size() > fs ? full_rise[fs] - acc[as0] : -1, 16);
    hold_o = 1'b0;
    feed_run(200, 1);
    wait_beats(bs, 48, 150);
    chk("t3_grants", {grants[gs], grants[gs+1], grants[gs+2]}, {32'd0, 32'd1, 32'd0});
    exp_c = {0, 1, 0}; exp_b = {0, 0, 1};
    check_stream("t3", bs);
    chk("t3_full_cleared", fifo_full, 0);

    // T4: reset in the middle of a block, then a fresh block streams from beat 0.
    do_reset();
    ds = dcyc.size();
    feed_init(1, 0);
    feed_run(10, 1);
    tick(5);
    rst = 1'b1; in_valid = 2'b10;
    in_data[1*(BL+1) +: BL+1] = {blk(1, 0), 1'b1};
    #1 chk("t4_ready_in_reset", in_ready, 0);
    tick(1);
    rst = 1'b0; in_valid = '0;
    chk("t4_d_out_zero", d_out, 0);
    chk("t4_full_zero", fifo_full, 0);
    bs = beats.size();
    tick(6);
    chk("t4_no_beats_after_reset", beats.size() - bs, 0);
    chk("t4_no_done", dcyc.size() - ds, 0);
    feed_init(0, 1);
    feed_run(10, 1);
    wait_beats(bs, 16, 40);
    exp_c = {1}; exp_b = {0};
    check_stream("t4", bs);
    chk("t4_done_fresh", dcyc.size() - ds, 1);

    // T5: full-width beats, one channel, a block every cycle.
    bs = beats5.size(); ds = dcyc5.size();
    v5 = 1'b1; d5 = {b5(0), 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_ready%0d", i), r5, 1);
      @(posedge clk); #1;
      if (i < 3) d5 = {b5(i + 1), 1'b1};
      else v5 = 1'b0;
    end
    tick(6);
    chk("t5_beat_count", beats5.size() - bs, 4);
    for (int i = 0; i < 4; i++)
      if (bs + i < beats5.size()) chk($sformatf("t5_beat%0d", i), beats5[bs+i], mk5(b5(i)));
    if (beats5.size() >= bs + 4) chk("t5_one_per_cycle", bcyc5[bs+3] - bcyc5[bs], 3);
    chk("t5_done_count", dcyc5.size() - ds, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
